wait_event_multi: RTL and testbench

//  Parametrised successor to the sequencer's wait-event stage. It holds one armed wait command at a time,

---
 rtl/wait_event_pkg.sv | 33 +++
 rtl/wait_cond_eval.sv | 29 ++
 rtl/wait_event_multi.sv | 155 +++++++++++++++
 tb/tb_wait_event_multi.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wait_event_pkg.sv
// Shared types for the wait-event stage: condition codes, FSM states and result kinds.
// Also holds the helper that decides whether a condition code is legal.
package wait_event_pkg;

   typedef enum logic [2:0] {
      WM_EQ   = 3'd0,
      WM_NEQ  = 3'd1,
      WM_RISE = 3'd2,
      WM_FALL = 3'd3,
      WM_CHG  = 3'd4
   } wait_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } wait_state_t;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_DONE = 2'd1,
      RES_TMO  = 2'd2,
      RES_ERR  = 2'd3
   } wait_res_t;

   localparam logic [2:0] MODE_MAX = 3'd4;

   function automatic logic mode_ok(input logic [2:0] mode);
      return (mode <= MODE_MAX);
   endfunction

endpackage

// File: rtl/wait_cond_eval.sv
// Combinational condition check for one armed wait: compares the selected channel
// (and its previous-cycle value) against the registered value/mask for the given mode.
module wait_cond_eval
   import wait_event_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] ch,
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] value,
   input  logic [WIDTH-1:0] mask,
   input  wait_mode_t       mode,
   output logic             hit
);

   always_comb begin
      hit = 1'b0;
      case (mode)
         WM_EQ:   hit = ((ch & mask) == (value & mask));
         WM_NEQ:  hit = ((ch & mask) != (value & mask));
         // Edge modes look only at bit 0 of the channel.
         WM_RISE: hit = !prev[0] && ch[0];
         WM_FALL: hit = prev[0] && !ch[0];
         WM_CHG:  hit = |((ch ^ prev) & mask);
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/wait_event_multi.sv
// Wait-event stage: holds one armed wait against one of WAIT_SIZE channels, with optional
// cycle timeout, and reports done / timeout / error as a one-cycle pulse in RESP.
module wait_event_multi
   import wait_event_pkg::*;
#(
   parameter  int WAIT_SIZE  = 5,
   parameter  int WAIT_WIDTH = 8,
   parameter  int TMO_WIDTH  = 32,
   localparam int SEL_W      = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   // Command handshake: a command transfers on a cycle with i_cmd_valid && o_cmd_ready;
   // o_cmd_ready is high only in IDLE and never depends on i_cmd_valid.
   input  logic                            i_cmd_valid,
   output logic                            o_cmd_ready,
   input  logic [SEL_W-1:0]                i_cmd_sel,
   input  logic [2:0]                      i_cmd_mode,
   input  logic [WAIT_WIDTH-1:0]           i_cmd_value,
   input  logic [WAIT_WIDTH-1:0]           i_cmd_mask,
   input  logic [TMO_WIDTH-1:0]            i_cmd_tmo,
   input  logic                            i_abort,
   input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] i_wait,
   output logic                            o_done,
   output logic                            o_timeout,
   output logic                            o_error,
   output logic                            o_busy,
   output wait_state_t                     o_state
);

   localparam logic [SEL_W:0]     SEL_LIMIT = (SEL_W + 1)'(WAIT_SIZE);
   localparam logic [TMO_WIDTH-1:0] CNT_ONE = TMO_WIDTH'(1);

   wait_state_t           state_q;
   wait_res_t             res_q;
   logic [SEL_W-1:0]      sel_q;
   wait_mode_t            mode_q;
   logic [WAIT_WIDTH-1:0] value_q;
   logic [WAIT_WIDTH-1:0] mask_q;
   logic [TMO_WIDTH-1:0]  tmo_q;
   logic                  tmo_en_q;
   logic [TMO_WIDTH-1:0]  cnt_q;
   logic [WAIT_WIDTH-1:0] prev_q;

   logic [WAIT_WIDTH-1:0] ch;
   logic                  hit;
   logic                  bad_cmd;
   logic                  expire;

   // Channel mux written as a compare loop so an out-of-range sel reads as zero.
   always_comb begin
      ch = '0;
      for (int k = 0; k < WAIT_SIZE; k++) begin
         if (sel_q == SEL_W'(k)) begin
            ch = i_wait[k*WAIT_WIDTH +: WAIT_WIDTH];
         end
      end
   end

   wait_cond_eval #(
      .WIDTH (WAIT_WIDTH)
   ) u_cond (
      .ch    (ch),
      .prev  (prev_q),
      .value (value_q),
      .mask  (mask_q),
      .mode  (mode_q),
      .hit   (hit)
   );

   assign bad_cmd = ({1'b0, i_cmd_sel} >= SEL_LIMIT) || !mode_ok(i_cmd_mode);

   // The last counted WAIT cycle is the one where the counter steps from 1 to 0.
   assign expire = tmo_en_q && (cnt_q == CNT_ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         res_q    <= RES_NONE;
         sel_q    <= '0;
         mode_q   <= WM_EQ;
         value_q  <= '0;
         mask_q   <= '0;
         tmo_q    <= '0;
         tmo_en_q <= 1'b0;
         cnt_q    <= '0;
         prev_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_cmd_valid) begin
                  sel_q    <= i_cmd_sel;
                  mode_q   <= wait_mode_t'(i_cmd_mode);
                  value_q  <= i_cmd_value;
                  mask_q   <= i_cmd_mask;
                  tmo_q    <= i_cmd_tmo;
                  tmo_en_q <= |i_cmd_tmo;
                  if (bad_cmd) begin
                     state_q <= RESP;
                     res_q   <= RES_ERR;
                  end else begin
                     state_q <= ARM;
                     res_q   <= RES_NONE;
                  end
               end
            end
            ARM: begin
               if (i_abort) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  prev_q  <= ch;
                  cnt_q   <= tmo_q;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (i_abort) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  prev_q <= ch;
                  if (tmo_en_q && (cnt_q != '0)) begin
                     cnt_q <= cnt_q - CNT_ONE;
                  end
                  // A match on the expiry cycle still reports done.
                  if (hit) begin
                     state_q <= RESP;
                     res_q   <= RES_DONE;
                  end else if (expire) begin
                     state_q <= RESP;
                     res_q   <= RES_TMO;
                  end
               end
            end
            RESP: begin
               state_q <= IDLE;
               res_q   <= RES_NONE;
            end
            default: begin
               state_q <= IDLE;
               res_q   <= RES_NONE;
            end
         endcase
      end
   end

   assign o_cmd_ready = (state_q == IDLE);
   assign o_busy      = (state_q == ARM) || (state_q == WAIT);
   assign o_done      = (state_q == RESP) && (res_q == RES_DONE);
   assign o_timeout   = (state_q == RESP) && (res_q == RES_TMO);
   assign o_error     = (state_q == RESP) && (res_q == RES_ERR);
   assign o_state     = state_q;

endmodule

// File: tb/tb_wait_event_multi.sv
// Bench for wait_event_multi: directed and random wait commands, results checked
// against an expected queue of {kind, cycle} entries.
module tb_wait_event_multi;
   import wait_event_pkg::*;

   localparam int WS = 5;
   localparam int WW = 8;
   localparam int TW = 32;
   localparam int SW = 3;

   localparam logic [1:0] K_DONE = 2'd1;
   localparam logic [1:0] K_TMO  = 2'd2;
   localparam logic [1:0] K_ERR  = 2'd3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_cmd_valid = 1'b0;
   logic              o_cmd_ready;
   logic [SW-1:0]     i_cmd_sel = '0;
   logic [2:0]        i_cmd_mode = '0;
   logic [WW-1:0]     i_cmd_value = '0;
   logic [WW-1:0]     i_cmd_mask = '0;
   logic [TW-1:0]     i_cmd_tmo = '0;
   logic              i_abort = 1'b0;
   logic [WS*WW-1:0]  i_wait = '0;
   logic              o_done;
   logic              o_timeout;
   logic              o_error;
   logic              o_busy;
   wait_state_t       o_state;

   int                n_checks = 0;
   int                n_fail = 0;
   int                cyc = 0;
   logic [17:0]       exp_q[$];

   wait_event_multi #(
      .WAIT_SIZE  (WS),
      .WAIT_WIDTH (WW),
      .TMO_WIDTH  (TW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_sel   (i_cmd_sel),
      .i_cmd_mode  (i_cmd_mode),
      .i_cmd_value (i_cmd_value),
      .i_cmd_mask  (i_cmd_mask),
      .i_cmd_tmo   (i_cmd_tmo),
      .i_abort     (i_abort),
      .i_wait      (i_wait),
      .o_done      (o_done),
      .o_timeout   (o_timeout),
      .o_error     (o_error),
      .o_busy      (o_busy),
      .o_state     (o_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [1:0] kind, input int at);
      exp_q.push_back({kind, 16'(at)});
   endtask

   task automatic set_ch(input int k, input logic [WW-1:0] v);
      i_wait[k*WW +: WW] = v;
   endtask

   // Lands on the first negedge at or after cycle c (never the current instant).
   task automatic wait_cycle(input int c);
      @(negedge clk);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [SW-1:0] sel, input logic [2:0] mode,
                           input logic [WW-1:0] value, input logic [WW-1:0] mask,
                           input logic [TW-1:0] tmo, output int t);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!o_cmd_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!o_cmd_ready) begin
         check("cmd_ready_wait", 32'(o_cmd_ready), 32'd1);
         t = cyc;
         return;
      end
      i_cmd_valid = 1'b1;
      i_cmd_sel   = sel;
      i_cmd_mode  = mode;
      i_cmd_value = value;
      i_cmd_mask  = mask;
      i_cmd_tmo   = tmo;
      t = cyc;
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || !o_cmd_ready) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0 || !o_cmd_ready) begin
         check("idle_wait", 32'(exp_q.size()), 32'd0);
      end
   endtask

   // Scoreboard: every result pulse must match the head of the expected queue.
   always @(negedge clk) begin : mon
      logic [1:0]  kind;
      logic [17:0] got;
      logic [17:0] e;
      if (!rst && (o_done || o_timeout || o_error)) begin
         kind = o_done ? K_DONE : (o_timeout ? K_TMO : K_ERR);
         got  = {kind, 16'(cyc)};
         check("pulse_onehot", 32'(o_done) + 32'(o_timeout) + 32'(o_error), 32'd1);
         check("busy_in_resp", 32'(o_busy), 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(got), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", 32'(got), 32'(e));
         end
      end
   end

   initial begin
      int t;
      int t2;
      int d;
      int tmo;
      int k;
      logic [WW-1:0] v;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(o_cmd_ready), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_timeout", 32'(o_timeout), 32'd0);
      check("rst_error", 32'(o_error), 32'd0);
      check("rst_state", 32'(o_state), 32'd0);
      rst = 1'b0;

      // EQ on ch2, match driven at T+6
      send_cmd(3'd2, 3'd0, 8'h5A, 8'hFF, 32'd0, t);
      push_exp(K_DONE, t + 7);
      wait_cycle(t + 1);
      check("eq_busy_arm", 32'(o_busy), 32'd1);
      check("eq_ready_arm", 32'(o_cmd_ready), 32'd0);
      wait_cycle(t + 6);
      set_ch(2, 8'h5A);
      wait_idle();
      set_ch(2, 8'h00);

      // RISE on ch0 with bit 0 already high at accept
      set_ch(0, 8'h01);
      send_cmd(3'd0, 3'd2, 8'h00, 8'hFF, 32'd0, t);
      push_exp(K_DONE, t + 9);
      wait_cycle(t + 4);
      set_ch(0, 8'h00);
      wait_cycle(t + 8);
      set_ch(0, 8'h01);
      wait_idle();
      set_ch(0, 8'h00);

      // Timeout with tmo=10
      send_cmd(3'd1, 3'd0, 8'hFF, 8'hFF, 32'd10, t);
      push_exp(K_TMO, t + 12);
      wait_cycle(t + 12);
      check("tmo_ready_resp", 32'(o_cmd_ready), 32'd0);
      wait_cycle(t + 13);
      check("tmo_ready_after", 32'(o_cmd_ready), 32'd1);

      // Match lands on the expiry cycle of tmo=3
      send_cmd(3'd3, 3'd0, 8'h33, 8'hFF, 32'd3, t);
      push_exp(K_DONE, t + 5);
      wait_cycle(t + 4);
      set_ch(3, 8'h33);
      wait_idle();
      set_ch(3, 8'h00);

      // Shortest timeout
      send_cmd(3'd3, 3'd0, 8'h77, 8'hFF, 32'd1, t);
      push_exp(K_TMO, t + 3);
      wait_idle();

      // Bad sel and bad mode
      send_cmd(3'd5, 3'd0, 8'h00, 8'h00, 32'd0, t);
      push_exp(K_ERR, t + 1);
      wait_cycle(t + 1);
      check("err_sel_busy", 32'(o_busy), 32'd0);
      wait_idle();
      send_cmd(3'd0, 3'd7, 8'h00, 8'h00, 32'd0, t);
      push_exp(K_ERR, t + 1);
      wait_cycle(t + 1);
      check("err_mode_busy", 32'(o_busy), 32'd0);
      wait_idle();

      // Abort mid-wait
      send_cmd(3'd1, 3'd0, 8'hAA, 8'hFF, 32'd0, t);
      wait_cycle(t + 4);
      i_abort = 1'b1;
      wait_cycle(t + 5);
      check("abort_ready", 32'(o_cmd_ready), 32'd1);
      check("abort_busy", 32'(o_busy), 32'd0);
      i_abort = 1'b0;
      repeat (3) @(negedge clk);

      // Abort while IDLE is ignored
      i_abort = 1'b1;
      send_cmd(3'd4, 3'd0, 8'h00, 8'h00, 32'd0, t);
      i_abort = 1'b0;
      push_exp(K_DONE, t + 3);
      wait_idle();

      // Reset in the middle of a wait drops the result
      send_cmd(3'd1, 3'd0, 8'hAA, 8'hFF, 32'd5, t);
      wait_cycle(t + 3);
      rst = 1'b1;
      wait_cycle(t + 4);
      check("rstmid_busy", 32'(o_busy), 32'd0);
      check("rstmid_ready", 32'(o_cmd_ready), 32'd1);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // CHG with mask 0x0F, then a back-to-back command
      send_cmd(3'd4, 3'd4, 8'h00, 8'h0F, 32'd0, t);
      push_exp(K_DONE, t + 8);
      wait_cycle(t + 4);
      set_ch(4, 8'h80);
      wait_cycle(t + 7);
      set_ch(4, 8'h82);
      send_cmd(3'd0, 3'd0, 8'h00, 8'h00, 32'd0, t2);
      push_exp(K_DONE, t2 + 3);
      check("b2b_accept", 32'(t2), 32'(t + 9));
      wait_idle();
      set_ch(4, 8'h00);

      // Random EQ matches racing random timeouts
      for (int n = 0; n < 12; n++) begin
         k   = $urandom_range(0, WS - 1);
         v   = 8'($urandom_range(0, 255));
         d   = $urandom_range(2, 8);
         tmo = $urandom_range(0, 6);
         set_ch(k, ~v);
         send_cmd(SW'(k), 3'd0, v, 8'hFF, 32'(tmo), t);
         if (tmo != 0 && d > tmo + 1) push_exp(K_TMO, t + 2 + tmo);
         else push_exp(K_DONE, t + d + 1);
         wait_cycle(t + d);
         set_ch(k, v);
         wait_idle();
      end

      wait_idle();
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
